// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h39;

endpackage

// File: rtl/i2c_line_sync.sv
// Bus-line synchronizer with rise/fall pulses; presets high so an idle bus
// looks idle straight out of reset.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= SYNC_STAGES'({sync, d});
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/i2c_responder.sv
// I2C register-access responder: 8-bit pointer write, then data writes or
// reads with auto-increment; register traffic is exposed as strobes.
module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       rd_stb,
  output logic [7:0] rd_reg,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .d(scl_in), .q(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .d(sda_in), .q(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e state, state_d;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx;
  logic [7:0] ptr;
  logic       rw;
  logic [1:0] vld_pipe;

  logic       start, stop, last_bit, ack_begin, ack_end, addr_hit;
  logic [7:0] rx_byte;

  assign start     = sda_fall & scl;
  assign stop      = sda_rise & scl;
  assign rx_byte   = {shreg, sda};
  assign addr_hit  = (rx_byte[7:1] == DEV_ADDR);
  // bit_cnt counts SCL rises in a 9-bit frame; 8/9 mark the ACK slot phases
  assign last_bit  = scl_rise && (bit_cnt == 4'd7);
  assign ack_begin = scl_fall && (bit_cnt == 4'd8);
  assign ack_end   = scl_fall && (bit_cnt == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = ST_ADDR;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR:      if (last_bit) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_REG:       if (last_bit) state_d = ST_REG_ACK;
        ST_WDATA:     if (last_bit) state_d = ST_WDATA_ACK;
        ST_RDATA:     if (last_bit) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: if (bit_cnt == 4'd8 && sda) state_d = ST_IGNORE;
        default: ;
      endcase
    end else if (ack_end) begin
      case (state)
        ST_ADDR_ACK:  state_d = (rw == I2C_READ) ? ST_RDATA : ST_REG;
        ST_REG_ACK,
        ST_WDATA_ACK: state_d = ST_WDATA;
        ST_RDATA_ACK: state_d = ST_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_oe   <= 1'b0;
      wr_stb   <= 1'b0;
      wr_reg   <= 8'h00;
      wr_data  <= 8'h00;
      rd_stb   <= 1'b0;
      rd_reg   <= 8'h00;
      busy     <= 1'b0;
      bit_cnt  <= 4'd0;
      shreg    <= 7'h00;
      tx       <= 8'h00;
      ptr      <= 8'h00;
      rw       <= I2C_WRITE;
      vld_pipe <= 2'b00;
    end else begin
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      vld_pipe <= {vld_pipe[0], rd_stb};
      if (start) begin
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (stop) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        if (scl_rise) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 4'd1;
        end else if (ack_end) begin
          bit_cnt <= 4'd0;
        end
        case (state)
          ST_ADDR: if (last_bit) begin
            busy <= addr_hit;
            if (addr_hit) rw <= rx_byte[0];
          end
          ST_ADDR_ACK: begin
            if (ack_begin) sda_oe <= 1'b1;
            if (scl_rise && bit_cnt == 4'd8 && rw == I2C_READ) begin
              rd_stb <= 1'b1;
              rd_reg <= ptr;
            end
            // a read hands the line straight from ACK to the first data MSB
            if (ack_end) begin
              if (rw == I2C_READ) begin
                sda_oe <= ~tx[7];
                tx     <= {tx[6:0], 1'b0};
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          ST_REG: if (last_bit) ptr <= rx_byte;
          ST_REG_ACK, ST_WDATA_ACK: begin
            if (ack_begin) sda_oe <= 1'b1;
            if (ack_end) begin
              sda_oe <= 1'b0;
              if (state == ST_WDATA_ACK) ptr <= ptr + 8'd1;
            end
          end
          ST_WDATA: if (last_bit) begin
            wr_stb  <= 1'b1;
            wr_reg  <= ptr;
            wr_data <= rx_byte;
          end
          ST_RDATA: if (scl_fall) begin
            sda_oe <= ~tx[7];
            tx     <= {tx[6:0], 1'b0};
          end
          ST_RDATA_ACK: begin
            if (ack_begin) sda_oe <= 1'b0;
            if (scl_rise && bit_cnt == 4'd8 && !sda) begin
              ptr    <= ptr + 8'd1;
              rd_reg <= ptr + 8'd1;
              rd_stb <= 1'b1;
            end
            if (ack_end) begin
              sda_oe <= ~tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
          end
          ST_IGNORE: begin
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
          default: ;
        endcase
      end
      // read data arrives two clocks after the strobe
      if (vld_pipe[1]) tx <= rd_data;
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bus-master tasks, strobe scoreboard, byte/ACK checks.
module tb_i2c_responder;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe, wr_stb, rd_stb, busy;
  logic [7:0] wr_reg, wr_data, rd_reg;
  logic [7:0] rd_data = 8'h00;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_responder #(.DEV_ADDR(7'h39), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_reg(rd_reg), .rd_data(rd_data), .busy(busy)
  );

  typedef struct packed { logic [7:0] r; logic [7:0] d; } wr_t;

  int         total = 0;
  int         bad = 0;
  int         quiet_hits = 0;
  int         h0;
  logic       quiet = 1'b0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_src[$];
  wr_t        e_wr;
  logic [7:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (quiet && (sda_oe || busy)) quiet_hits++;
      if (wr_stb) begin
        if (exp_wr.size() == 0) chk("wr_unexp", exp_wr.size(), 1);
        else begin
          e_wr = exp_wr.pop_front();
          chk("wr_reg", wr_reg, e_wr.r);
          chk("wr_data", wr_data, e_wr.d);
        end
      end
      if (rd_stb) begin
        if (exp_rd.size() == 0) chk("rd_unexp", exp_rd.size(), 1);
        else begin
          e_rd = exp_rd.pop_front();
          chk("rd_reg", rd_reg, e_rd);
        end
        rd_data = (rd_src.size() != 0) ? rd_src.pop_front() : 8'h00;
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q(); sda_m = 1'b0; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(); scl = 1'b1; wait_q(); sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    send_bits(b);
    sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q();
    chk(tag, !sda_in, exp_ack);
    wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack, input string tag);
    logic [7:0] b;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q(); scl = 1'b1; wait_q(); b[i] = sda_in; wait_q(); scl = 1'b0;
    end
    sda_m = ~ack; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
    sda_m = 1'b1;
    chk(tag, b, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", sda_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_rd_stb", rd_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_reg", rd_reg, 0);
    rst = 1'b0;
    wait_q();

    // simple write, then read back where the pointer ended up
    i2c_start();
    write_byte({7'h39, I2C_WRITE}, 1'b1, "w1_addr_ack");
    chk("w1_busy_on", busy, 1);
    write_byte(8'h41, 1'b1, "w1_reg_ack");
    exp_wr.push_back('{r: 8'h41, d: 8'h10});
    write_byte(8'h10, 1'b1, "w1_data_ack");
    i2c_stop();
    chk("w1_busy_off", busy, 0);
    i2c_start();
    exp_rd.push_back(8'h42); rd_src.push_back(8'h5A);
    write_byte({7'h39, I2C_READ}, 1'b1, "p_addr_ack");
    read_byte(8'h5A, 1'b0, "p_byte");
    i2c_stop();

    // pointer set, repeated START, two-byte read ending in NACK
    i2c_start();
    write_byte(8'h72, 1'b1, "r_addr_ack");
    write_byte(8'h05, 1'b1, "r_reg_ack");
    i2c_start();
    exp_rd.push_back(8'h05); rd_src.push_back(8'hA5);
    exp_rd.push_back(8'h06); rd_src.push_back(8'h3C);
    write_byte(8'h73, 1'b1, "r_raddr_ack");
    read_byte(8'hA5, 1'b1, "r_byte0");
    read_byte(8'h3C, 1'b0, "r_byte1");
    chk("r_ign_busy", busy, 0);
    h0 = quiet_hits; quiet = 1'b1;
    write_byte(8'h00, 1'b0, "r_ign_nack");
    quiet = 1'b0;
    chk("r_ign_quiet", quiet_hits - h0, 0);
    i2c_stop();

    // foreign address
    h0 = quiet_hits; quiet = 1'b1;
    i2c_start();
    write_byte(8'hA0, 1'b0, "bad_addr");
    write_byte(8'h55, 1'b0, "bad_data");
    i2c_stop();
    quiet = 1'b0;
    chk("bad_quiet", quiet_hits - h0, 0);

    // pointer wrap
    i2c_start();
    write_byte(8'h72, 1'b1, "wr_addr_ack");
    write_byte(8'hFF, 1'b1, "wr_reg_ack");
    exp_wr.push_back('{r: 8'hFF, d: 8'h01});
    write_byte(8'h01, 1'b1, "wr_d0_ack");
    exp_wr.push_back('{r: 8'h00, d: 8'h02});
    write_byte(8'h02, 1'b1, "wr_d1_ack");
    i2c_stop();

    // reset while the address ACK is on the bus
    i2c_start();
    send_bits(8'h72);
    chk("ra_ack_drv", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("ra_rst_oe", sda_oe, 0);
    chk("ra_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_q(); scl = 1'b1; wait_q();
    i2c_start();
    write_byte(8'h72, 1'b1, "ra_addr_ack");
    write_byte(8'h10, 1'b1, "ra_reg_ack");
    exp_wr.push_back('{r: 8'h10, d: 8'h77});
    write_byte(8'h77, 1'b1, "ra_data_ack");
    i2c_stop();

    // STOP in the middle of a data byte
    i2c_start();
    write_byte(8'h72, 1'b1, "sm_addr_ack");
    write_byte(8'h20, 1'b1, "sm_reg_ack");
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    i2c_stop();
    chk("sm_busy", busy, 0);
    i2c_start();
    exp_rd.push_back(8'h20); rd_src.push_back(8'h99);
    write_byte(8'h73, 1'b1, "sm_raddr_ack");
    read_byte(8'h99, 1'b0, "sm_byte");
    i2c_stop();

    repeat (4) @(posedge clk);
    #1;
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
